// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding select
// encodings, mul/div tracker state type and a register-match helper.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef logic [1:0] md_state_t;

    localparam md_state_t MD_IDLE = 2'd0;
    localparam md_state_t MD_BUSY = 2'd1;
    localparam md_state_t MD_DONE = 2'd2;

    // Source register matches a destination; $zero never matches
    function automatic logic src_match(input logic used, input logic [4:0] src,
                                       input logic [4:0] dst);
        return used && (src != 5'd0) && (src == dst);
    endfunction

    // EX/MEM result has priority over MEM/WB
    function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
        if (ex_hit) begin
            return FWD_EXMEM;
        end else if (mem_hit) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_muldiv_tracker.sv
// Tracks occupancy of the multi-cycle mul/div unit (IDLE -> BUSY -> DONE).
module muldiv_tracker
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_ok,
    output logic busy
);

    localparam int unsigned CNT_W = 4;

    md_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Next-state and down-counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (start_ok) begin
                    state_d = MD_BUSY;
                    cnt_d   = CNT_W'(MULDIV_CYCLES - 1);
                end
            end
            MD_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = MD_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            MD_DONE: begin
                if (start_ok) begin
                    state_d = MD_BUSY;
                    cnt_d   = CNT_W'(MULDIV_CYCLES - 1);
                end else begin
                    state_d = MD_IDLE;
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy    <= (state_d == MD_BUSY);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use / hi-lo stalls, branch flush,
// registered EX operand forwarding and stall statistics.
// Optional feature: define FORWARDING_EN to enable forwarding; otherwise
// every RAW dependency on EX or MEM stalls and fwd_a/fwd_b stay 00.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = 4,
    parameter int unsigned STALL_CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    input  logic [4:0]             ex_rd,
    input  logic [4:0]             mem_rd,
    input  logic                   ex_regwrite,
    input  logic                   ex_memread,
    input  logic                   mem_regwrite,
    input  logic                   ex_branch_taken,
    input  logic                   id_muldiv_start,
    input  logic                   id_reads_hilo,
    output logic                   pc_stall,
    output logic                   ifid_stall,
    output logic                   idex_bubble,
    output logic                   ifid_flush,
    output logic [1:0]             fwd_a,
    output logic [1:0]             fwd_b,
    output logic                   muldiv_busy,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic rs_ex, rt_ex, rs_mem, rt_mem;
    logic load_use, hilo_stall, raw_stall, stall, start_ok;

    // Hazard detection against the instructions in EX and MEM
    always_comb begin
        rs_ex      = src_match(id_uses_rs, id_rs, ex_rd);
        rt_ex      = src_match(id_uses_rt, id_rt, ex_rd);
        rs_mem     = src_match(id_uses_rs, id_rs, mem_rd);
        rt_mem     = src_match(id_uses_rt, id_rt, mem_rd);
        load_use   = ex_memread & (rs_ex | rt_ex);
        hilo_stall = muldiv_busy & (id_reads_hilo | id_muldiv_start);
`ifdef FORWARDING_EN
        raw_stall  = 1'b0;
`else
        raw_stall  = (ex_regwrite & (rs_ex | rt_ex)) | (mem_regwrite & (rs_mem | rt_mem));
`endif
        stall      = load_use | hilo_stall | raw_stall;
        start_ok   = id_muldiv_start & ~stall & ~ex_branch_taken;
    end

    // Pipeline control; a taken branch overrides any stall
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (stall) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
        end
    end

`ifdef FORWARDING_EN
    logic [1:0] fwd_a_d, fwd_b_d;

    // Forwarding select computed for the instruction about to enter EX
    always_comb begin
        fwd_a_d = fwd_sel(ex_regwrite & rs_ex, mem_regwrite & rs_mem);
        fwd_b_d = fwd_sel(ex_regwrite & rt_ex, mem_regwrite & rt_mem);
    end

    // Forwarding selects travel with the instruction into EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a <= FWD_RF;
            fwd_b <= FWD_RF;
        end else if (idex_bubble) begin
            fwd_a <= FWD_RF;
            fwd_b <= FWD_RF;
        end else if (!ifid_stall) begin
            fwd_a <= fwd_a_d;
            fwd_b <= fwd_b_d;
        end
    end
`else
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
`endif

    // Saturating count of genuine stall cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && !ex_branch_taken && !(&stall_count)) begin
            stall_count <= stall_count + STALL_CNT_W'(1);
        end
    end

    muldiv_tracker #(
        .MULDIV_CYCLES (MULDIV_CYCLES)
    ) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_ok (start_ok),
        .busy     (muldiv_busy)
    );

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MULDIV_CYCLES, default 4, latency in cycles of the multi-cycle mul/div unit (legal range 2..15).
REQ-002 SHALL have parameter STALL_CNT_W, default 16, width of the stall statistics counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-006 id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads that source.
REQ-007 ex_rd, mem_rd  in  5 each  destination registers in EX and MEM.
REQ-008 ex_regwrite, ex_memread, mem_regwrite  in  1 each  write-enable and load flags for EX and MEM.
REQ-009 ex_branch_taken  in  1  branch/jump in EX resolved as taken.
REQ-010 id_muldiv_start, id_reads_hilo  in  1 each  ID instruction is mult/div, or is mfhi/mflo.
REQ-011 pc_stall, ifid_stall, idex_bubble, ifid_flush  out  1 each  pipeline control.
REQ-012 fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 10 EX/MEM ALUOut, 01 MEM/WB.
REQ-013 muldiv_busy  out  1  mul/div unit occupied; stall_count  out  STALL_CNT_W  stall cycles seen.

Function
REQ-014 Register 0 SHALL never cause a hazard or forwarding match.
REQ-015 Load-use: ex_memread and ex_rd matches a used ID source -> stall = 1 (combinational, same cycle).
REQ-016 Hi/lo: muldiv_busy and (id_reads_hilo or id_muldiv_start) -> stall = 1.
REQ-017 stall SHALL drive pc_stall=1, ifid_stall=1, idex_bubble=1.
REQ-018 ex_branch_taken SHALL win over any stall: ifid_flush=1, idex_bubble=1, pc_stall=0, ifid_stall=0; ID start/read requests ignored that cycle.
REQ-019 fwd_a/fwd_b SHALL be registered (1-cycle latency, aligned with the instruction entering EX): ex_regwrite and ex_rd match -> 10; else mem_regwrite and mem_rd match -> 01; else 00.
REQ-020 When idex_bubble=1, fwd_a/fwd_b SHALL load 00; when ifid_stall=1 without bubble, they SHALL hold.
REQ-021 Mul/div FSM states IDLE, BUSY, DONE: IDLE->BUSY on id_muldiv_start with no stall and no branch flush; counter loads MULDIV_CYCLES-1.
REQ-022 BUSY decrements each cycle; at counter 0 -> DONE; DONE->IDLE next cycle, or DONE->BUSY if a new accepted start occurs.
REQ-023 muldiv_busy=1 in BUSY only; DONE means hi/lo valid, mfhi/mflo may proceed.
REQ-024 stall_count SHALL increment once per cycle with stall=1 and not ex_branch_taken, saturating at all-ones.

Reset
REQ-025 rst_n low SHALL immediately force FSM=IDLE, counter=0, fwd_a=fwd_b=00, muldiv_busy=0, stall_count=0.
REQ-026 Reset mid-BUSY SHALL abandon the operation; first cycle after release behaves as IDLE.
REQ-027 Combinational outputs SHALL follow inputs during reset, but the FSM contributes no stall.

Configuration
REQ-028 Macro FORWARDING_EN defined: behaviour as above.
REQ-029 FORWARDING_EN undefined: fwd_a=fwd_b=00 always, and any used-source match against EX or MEM (regwrite set) SHALL stall until clear; WB needs no stall (regfile write-before-read).

Structure
REQ-030 Shared package SHALL hold the fwd select encodings (FWD_RF, FWD_EXMEM, FWD_MEMWB) and the FSM state typedef.
REQ-031 Sub-module muldiv_tracker SHALL contain the FSM and down-counter; hazard and forwarding logic stays at top level.

Verification
REQ-032 lw $s1 in EX (ex_rd=19, memread), ID add uses rs=19 -> one-cycle stall, then fwd_a=01 when add reaches EX; stall_count=1.
REQ-033 EX add writes rd=20, ID uses rt=20 -> no stall, next cycle fwd_b=10; same with rd=0 -> fwd_b=00.
REQ-034 EX writes 21 and MEM writes 21, ID uses 21 -> fwd=10 (EX priority).
REQ-035 mult in ID, then mflo next -> muldiv_busy 4 cycles (MULDIV_CYCLES=4), mflo stalled exactly 4 cycles, proceeds in DONE.
REQ-036 Load-use stall and ex_branch_taken same cycle -> ifid_flush=1, pc_stall=0, stall_count unchanged.
REQ-037 rst_n low in 2nd BUSY cycle -> muldiv_busy=0 immediately; without FORWARDING_EN, scenario REQ-033 stalls 2 cycles.
